// File: rtl/fix_byte_unpacker.sv
// Unpacks length-prefixed messages from a wide FIFO into a byte stream.
// A header word carries the message ID and payload length; payload words follow.
module fix_byte_unpacker #(
    parameter int DATA_W = 64,
    parameter int ID_W   = 2,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              error_i,
    input  logic              ready_i,
    output logic              readreq_o,
    output logic              valid_o,
    output logic [7:0]        data_o,
    output logic [ID_W-1:0]   id_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              err_o,
    output logic [15:0]       msg_cnt_o
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, HDR, STARVE, LOAD, SEND} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    byte_q, byte_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [15:0]         msg_cnt_q, msg_cnt_d;
    logic                err_q, err_d;
    logic                rdreq_prev_q;
    logic                rdreq;
    logic                last_lane;
    logic                last_byte;
    logic [7:0]          lane_bytes [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_bytes[gi] = word_q[gi*8 +: 8];
    end

    assign last_lane = (lane_q == LANE_W'(LANES - 1));
    assign last_byte = (byte_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        byte_d    = byte_q;
        lane_d    = lane_q;
        word_d    = word_q;
        msg_cnt_d = msg_cnt_q;
        err_d     = 1'b0;
        rdreq     = 1'b0;

        // A pop is never issued in the cycle right after another pop, so the
        // header pop is always followed by a trip through STARVE.
        case (state_q)
            IDLE: begin
                if (!empty_i && !rdreq_prev_q) begin
                    rdreq   = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                id_d   = data_i[ID_W-1:0];
                len_d  = data_i[4 +: LEN_W];
                byte_d = '0;
                lane_d = '0;
                if (data_i[4 +: LEN_W] == '0) begin
                    state_d = IDLE;
                end else if (!empty_i && !rdreq_prev_q) begin
                    rdreq   = 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = STARVE;
                end
            end
            STARVE: begin
                if (!empty_i && !rdreq_prev_q) begin
                    rdreq   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                word_d  = data_i;
                lane_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (ready_i) begin
                    if (last_byte) begin
                        msg_cnt_d = msg_cnt_q + 16'd1;
                        state_d   = IDLE;
                    end else if (last_lane) begin
                        byte_d = byte_q + LEN_W'(1);
                        if (!empty_i && !rdreq_prev_q) begin
                            rdreq   = 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = STARVE;
                        end
                    end else begin
                        byte_d = byte_q + LEN_W'(1);
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over whatever the state logic decided, including a transfer.
        if (error_i && state_q != IDLE) begin
            state_d   = IDLE;
            id_d      = id_q;
            len_d     = len_q;
            byte_d    = byte_q;
            lane_d    = lane_q;
            word_d    = word_q;
            msg_cnt_d = msg_cnt_q;
            err_d     = 1'b1;
            rdreq     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            id_q         <= '0;
            len_q        <= '0;
            byte_q       <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            msg_cnt_q    <= '0;
            err_q        <= 1'b0;
            rdreq_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            len_q        <= len_d;
            byte_q       <= byte_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            msg_cnt_q    <= msg_cnt_d;
            err_q        <= err_d;
            rdreq_prev_q <= rdreq;
        end
    end

    assign readreq_o = rdreq && !rst;
    assign valid_o   = (state_q == SEND);
    assign data_o    = lane_bytes[lane_q];
    assign id_o      = id_q;
    assign sop_o     = valid_o && (byte_q == '0);
    assign eop_o     = valid_o && last_byte;
    assign err_o     = err_q;
    assign msg_cnt_o = msg_cnt_q;

endmodule

// File: doc/fix_byte_unpacker.md
FIX_BYTE_UNPACKER -- requirements
Module: fix_byte_unpacker

Interface
REQ-001 SHALL have parameter DATA_W, default 64, FIFO word width; a multiple of 8 in the range 32..256.
REQ-002 SHALL have parameter ID_W, default 2, message-ID width; header bits [ID_W-1:0].
REQ-003 SHALL have parameter LEN_W, default 15, payload byte-length width; header bits [4 +: LEN_W]; 4+LEN_W <= DATA_W.
REQ-004 SHALL have port clk  input  1  clock, with all logic on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port empty_i  input  1  upstream FIFO empty.
REQ-007 SHALL have port data_i  input  DATA_W  FIFO read data, valid the cycle after readreq_o and held until the next readreq_o.
REQ-008 SHALL have port error_i  input  1  upstream abort request.
REQ-009 SHALL have port ready_i  input  1  downstream accepts the byte.
REQ-010 SHALL have port readreq_o  output  1  one-cycle FIFO pop request.
REQ-011 SHALL have port valid_o  output  1  data_o holds a payload byte.
REQ-012 SHALL have port data_o  output  8  payload byte.
REQ-013 SHALL have port id_o  output  ID_W  ID of the current message.
REQ-014 SHALL have port sop_o  output  1  marks the first payload byte, qualified by valid_o.
REQ-015 SHALL have port eop_o  output  1  marks the last payload byte, qualified by valid_o.
REQ-016 SHALL have port err_o  output  1  one-cycle abort pulse.
REQ-017 SHALL have port msg_cnt_o  output  16  count of completed messages, wrapping.

Function
REQ-018 SHALL implement the states IDLE, HDR, STARVE, LOAD and SEND.
REQ-019 IDLE SHALL assert readreq_o when empty_i=0 (combinational on empty_i) and go to HDR; otherwise it SHALL stay in IDLE.
REQ-020 HDR SHALL latch id and length from data_i and clear the byte and lane counters.
REQ-021 On leaving HDR, length=0 SHALL go to IDLE with no output; otherwise empty_i=0 SHALL pulse readreq_o and go to LOAD, else go to STARVE.
REQ-022 STARVE SHALL hold with readreq_o=0 until empty_i=0, then pulse readreq_o and go to LOAD.
REQ-023 LOAD SHALL register data_i into the word buffer, set lane=0 and go to SEND.
REQ-024 SEND SHALL drive valid_o=1 and data_o = word[lane*8 +: 8], using little-endian lanes (byte 0 = bits [7:0]).
REQ-025 A byte SHALL be transferred only when valid_o=1 and ready_i=1; otherwise data_o, sop_o, eop_o and id_o SHALL be held unchanged.
REQ-026 sop_o SHALL be 1 while the byte counter is 0; eop_o SHALL be 1 while the byte counter equals length-1.
REQ-027 On a transfer with eop_o=1, the block SHALL increment msg_cnt_o (modulo 2^16) and go to IDLE, discarding the remaining lanes of the word.
REQ-028 On a non-eop transfer at lane DATA_W/8-1, the block SHALL pulse readreq_o if empty_i=0 and go to LOAD, else go to STARVE; this gives exactly one bubble cycle per word.
REQ-029 On any other transfer, the block SHALL increment lane and the byte counter and stay in SEND.
REQ-030 valid_o, sop_o and eop_o SHALL be 0 in every state other than SEND.
REQ-031 valid_o SHALL NOT depend combinationally on ready_i.
REQ-032 readreq_o SHALL never assert in two consecutive cycles.
REQ-033 error_i=1 in any state other than IDLE SHALL force IDLE on the next edge and pulse err_o for one cycle.
REQ-034 On that abort, valid_o SHALL be 0 from the next cycle, no readreq_o SHALL be issued in the error cycle, and msg_cnt_o SHALL be unchanged.
REQ-035 error_i SHALL take priority over a simultaneous transfer; that byte counts as not delivered.
REQ-036 error_i=1 in IDLE SHALL be ignored.
REQ-037 Lengths up to 2^LEN_W-1 SHALL be supported; a counter SHALL never wrap within a message.

Reset
REQ-038 With rst=1 the block SHALL go to IDLE.
REQ-039 With rst=1 the outputs SHALL read readreq_o=0, valid_o=0, data_o=0, id_o=0, sop_o=0, eop_o=0, err_o=0, msg_cnt_o=0.
REQ-040 With rst=1 the byte and lane counters SHALL be cleared.
REQ-041 Reset SHALL take priority over error_i and over any transfer.
REQ-042 Reset mid-message SHALL drop that message silently, with no err_o pulse.

Verification (DATA_W=64, ID_W=2, LEN_W=15)
REQ-043 Header id=2, len=3; word 0x0000_0000_00CC_BBAA; ready_i=1 -> bytes AA,BB,CC in 3 consecutive cycles, sop on AA, eop on CC, id_o=2, msg_cnt_o=1.
REQ-044 len=10 with two words -> 8 bytes, 1 bubble cycle, 2 bytes; the unused 6 bytes are never output; exactly 3 readreq_o pulses in total.
REQ-045 ready_i=0 for 3 cycles at byte 4 -> valid_o=1 held and data_o stable for 3 cycles, then byte 4 transfers once.
REQ-046 empty_i=1 after the header for 5 cycles -> STARVE with valid_o=0 and no readreq_o, then normal delivery once empty_i=0.
REQ-047 error_i pulsed during byte 4 of len=10 -> err_o=1 for one cycle, valid_o=0 next cycle, msg_cnt_o unchanged, and the next header is accepted normally.
REQ-048 Header with len=0, then rst asserted mid-message -> no valid_o and msg_cnt_o unchanged; all outputs at reset values the cycle after rst.
